// File: rtl/exc_pipe_tracker.sv
// Tracks exception state alongside each instruction through NUM_STAGES pipeline slots
// and issues one registered, precise exception request (plus pipeline flush) at commit.
module exc_pipe_tracker #(
    parameter int NUM_STAGES = 4,
    parameter int PC_W       = 32,
    parameter int CODE_W     = 5,
    parameter int NUM_IRQ    = 6
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [PC_W-1:0]              pc_in,
    input  logic                         bd_in,
    input  logic [NUM_STAGES-1:0]        hold,
    input  logic                         flush,
    input  logic [NUM_STAGES-1:0]        exc_in,
    input  logic [NUM_STAGES*CODE_W-1:0] exc_code_in,
    input  logic [NUM_IRQ-1:0]           hw_int,
    input  logic [NUM_IRQ-1:0]           im,
    input  logic                         ie,
    input  logic                         exl,
    output logic                         exc_req,
    output logic [CODE_W-1:0]            exc_code_out,
    output logic [PC_W-1:0]              epc_out,
    output logic                         bd_out,
    output logic                         epc_we,
    output logic                         flush_out,
    output logic [NUM_STAGES-1:0]        slot_exc
);

    localparam int LAST = NUM_STAGES - 1;

    logic [NUM_STAGES-1:0] valid_q, valid_d;
    logic [NUM_STAGES-1:0] exc_q, exc_d;
    logic [NUM_STAGES-1:0] bd_q, bd_d;
    logic [CODE_W-1:0]     code_q [NUM_STAGES];
    logic [CODE_W-1:0]     code_d [NUM_STAGES];
    logic [PC_W-1:0]       pc_q [NUM_STAGES];
    logic [PC_W-1:0]       pc_d [NUM_STAGES];

    logic                  excReq_q;
    logic [CODE_W-1:0]     excCode_q;
    logic [PC_W-1:0]       epc_q;
    logic                  bdOut_q;
    logic                  epcWe_q;

    logic [NUM_STAGES-1:0] held;
    logic [NUM_STAGES-1:0] effExc;
    logic [CODE_W-1:0]     effCode [NUM_STAGES];
    logic                  intPend;
    logic                  excReqNext;
    logic [PC_W-1:0]       commitEpc;

    // A stall in any later slot freezes every earlier slot, so holds are widened to a prefix.
    always_comb begin
        held = '0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            held[k] = |(hold >> k);
        end
    end

    // An exception already carried by a slot is older than any new raise and wins.
    always_comb begin
        effExc = valid_q & (exc_q | exc_in);
        for (int k = 0; k < NUM_STAGES; k++) begin
            effCode[k] = exc_q[k] ? code_q[k] : exc_code_in[k*CODE_W +: CODE_W];
        end
    end

    assign intPend    = (|(hw_int & im)) & ie & ~exl;
    assign excReqNext = valid_q[LAST] & (intPend | effExc[LAST]) & ~flush;
    assign commitEpc  = bd_q[LAST] ? (pc_q[LAST] - PC_W'(4)) : pc_q[LAST];

    always_comb begin
        valid_d = valid_q;
        exc_d   = exc_q;
        bd_d    = bd_q;
        for (int k = 0; k < NUM_STAGES; k++) begin
            code_d[k] = code_q[k];
            pc_d[k]   = pc_q[k];
        end

        if (flush || excReqNext) begin
            valid_d = '0;
            exc_d   = '0;
        end else begin
            if (held[0]) begin
                exc_d[0]  = effExc[0];
                code_d[0] = effCode[0];
            end else begin
                valid_d[0] = 1'b1;
                exc_d[0]   = 1'b0;
                pc_d[0]    = pc_in;
                bd_d[0]    = bd_in;
            end

            // A slot whose predecessor is frozen receives a bubble instead of a duplicate.
            for (int k = 1; k < NUM_STAGES; k++) begin
                if (held[k]) begin
                    exc_d[k]  = effExc[k];
                    code_d[k] = effCode[k];
                end else if (held[k-1]) begin
                    valid_d[k] = 1'b0;
                    exc_d[k]   = 1'b0;
                end else begin
                    valid_d[k] = valid_q[k-1];
                    exc_d[k]   = effExc[k-1];
                    code_d[k]  = effCode[k-1];
                    pc_d[k]    = pc_q[k-1];
                    bd_d[k]    = bd_q[k-1];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
            exc_q   <= '0;
            bd_q    <= '0;
            for (int k = 0; k < NUM_STAGES; k++) begin
                code_q[k] <= '0;
                pc_q[k]   <= '0;
            end
        end else begin
            valid_q <= valid_d;
            exc_q   <= exc_d;
            bd_q    <= bd_d;
            for (int k = 0; k < NUM_STAGES; k++) begin
                code_q[k] <= code_d[k];
                pc_q[k]   <= pc_d[k];
            end
        end
    end

    // Cause, EPC and BD keep their last captured values between requests.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            excReq_q  <= 1'b0;
            excCode_q <= '0;
            epc_q     <= '0;
            bdOut_q   <= 1'b0;
            epcWe_q   <= 1'b0;
        end else begin
            excReq_q <= excReqNext;
            epcWe_q  <= excReqNext & ~exl;
            if (excReqNext) begin
                excCode_q <= intPend ? '0 : effCode[LAST];
                epc_q     <= commitEpc;
                bdOut_q   <= bd_q[LAST];
            end
        end
    end

    assign exc_req      = excReq_q;
    assign exc_code_out = excCode_q;
    assign epc_out      = epc_q;
    assign bd_out       = bdOut_q;
    assign epc_we       = epcWe_q;
    assign flush_out    = excReq_q | flush;
    assign slot_exc     = valid_q & exc_q;

endmodule
